// File: rtl/down_timer_if.sv
// Bus bundle for down_timer: load/start/stop controls in, count and flags out.
// The master drives the controls and the slave (the timer) drives the status.
interface down_timer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  i_le;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_start;
    logic                  i_stop;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_busy;
    logic                  o_tc;

    modport master (
        output i_le, i_data, i_start, i_stop,
        input  o_data, o_busy, o_tc
    );

    modport slave (
        input  i_le, i_data, i_start, i_stop,
        output o_data, o_busy, o_tc
    );
endinterface

// File: rtl/down_timer.sv
// down_timer: loadable down-counter with pause/resume and a one-cycle
// terminal-count pulse on the 1 -> 0 transition.
// Build option: define TIMER_AUTORELOAD_EN for periodic mode, where the count
// reloads on terminal count and the timer stays running (DONE is never used).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | stopped; count held (after load, pause or reset)
// RUN   | counting down one per edge; o_busy high
// DONE  | one-shot expired; count is 0, start re-arms from reload value
module down_timer #(
    parameter int DATA_WIDTH = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    down_timer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] ONE  = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] ZERO = '0;

    state_t                state;
    logic [DATA_WIDTH-1:0] count;
    logic [DATA_WIDTH-1:0] reload;
    logic                  tc;
    logic                  busy;

    // Control FSM, counter and registered flags; load beats stop beats start.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state  <= IDLE;
            count  <= ZERO;
            reload <= ZERO;
            tc     <= 1'b0;
            busy   <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (bus.i_le) begin
                reload <= bus.i_data;
                count  <= bus.i_data;
                state  <= IDLE;
                busy   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        // A stop here is a no-op but still masks a same-cycle start.
                        if (!bus.i_stop && bus.i_start && (count != ZERO)) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (bus.i_stop) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (count == ONE) begin
                            tc <= 1'b1;
`ifdef TIMER_AUTORELOAD_EN
                            count <= reload;
`else
                            count <= ZERO;
                            state <= DONE;
                            busy  <= 1'b0;
`endif
                        end else if (count != ZERO) begin
                            count <= count - ONE;
                        end
                    end
                    DONE: begin
                        if (!bus.i_stop && bus.i_start && (reload != ZERO)) begin
                            count <= reload;
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.o_data = count;
    assign bus.o_busy = busy;
    assign bus.o_tc   = tc;

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed scenarios plus random traffic,
// every cycle compared against a flag-based behavioural model.
module tb_down_timer;
    localparam int DW = 16;

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;

    down_timer_if #(.DATA_WIDTH(DW)) bus ();

    down_timer #(.DATA_WIDTH(DW)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;
    int tc_count = 0;

    // Reference model: a count, a reload value, "running" and "expired" flags.
    int unsigned m_cnt;
    int unsigned m_rel;
    bit m_run;
    bit m_exp;
    bit m_tc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_rel = 0; m_run = 0; m_exp = 0; m_tc = 0;
    endtask

    task automatic model_step(input bit le, input int unsigned d, input bit st, input bit sp);
        m_tc = 0;
        if (le) begin
            m_rel = d; m_cnt = d; m_run = 0; m_exp = 0;
        end else if (sp) begin
            m_run = 0;
        end else if (m_run) begin
            if (m_cnt == 1) begin
                m_tc = 1;
`ifdef TIMER_AUTORELOAD_EN
                m_cnt = m_rel;
`else
                m_cnt = 0; m_run = 0; m_exp = 1;
`endif
            end else if (m_cnt > 0) begin
                m_cnt = m_cnt - 1;
            end
        end else if (st) begin
            if (!m_exp && m_cnt != 0) m_run = 1;
            else if (m_exp && m_rel != 0) begin
                m_cnt = m_rel; m_run = 1; m_exp = 0;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_data"}, 32'(bus.o_data), m_cnt);
        chk({tag, "_busy"}, 32'(bus.o_busy), 32'(m_run));
        chk({tag, "_tc"},   32'(bus.o_tc),   32'(m_tc));
    endtask

    task automatic cyc(input string tag, input bit le, input int unsigned d, input bit st, input bit sp);
        bus.i_le    = le;
        bus.i_data  = DW'(d);
        bus.i_start = st;
        bus.i_stop  = sp;
        @(posedge i_clk);
        model_step(le, d, st, sp);
        #1;
        check_outputs(tag);
        if (bus.o_tc) tc_count++;
        bus.i_le = 0; bus.i_start = 0; bus.i_stop = 0;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 0, 0, 0, 0);
    endtask

    initial begin
        int lat;
        int exp_pulses;
        bus.i_le = 0; bus.i_data = '0; bus.i_start = 0; bus.i_stop = 0;
        model_reset();

        // reset state, held with clock running
        #12;
        chk("rst_data", 32'(bus.o_data), 0);
        chk("rst_busy", 32'(bus.o_busy), 0);
        chk("rst_tc",   32'(bus.o_tc),   0);
        @(negedge i_clk);
        i_rst = 1'b1;

        // one-shot: load 3, start, tc 3 edges later
        cyc("os_load", 1, 3, 0, 0);
        cyc("os_start", 0, 0, 1, 0);
        tc_count = 0;
        idle("os_run", 3);
        chk("os_tc_at3", 32'(bus.o_tc), 1);
        idle("os_after", 3);
        chk("os_pulses", tc_count, 1);

        // pause at 6 and resume: tc 6 edges after resume
        cyc("pr_load", 1, 10, 0, 0);
        cyc("pr_start", 0, 0, 1, 0);
        idle("pr_run", 4);
        cyc("pr_stop", 0, 0, 0, 1);
        idle("pr_hold", 4);
        chk("pr_held", 32'(bus.o_data), 6);
        cyc("pr_resume", 0, 0, 1, 0);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc("pr_lat", 0, 0, 0, 0);
            if (bus.o_tc) begin lat = k; break; end
        end
        chk("pr_latency", lat, 6);

        // priority: load beats stop and start; stop beats start in RUN
        cyc("pri_all", 1, 7, 1, 1);
        chk("pri_data", 32'(bus.o_data), 7);
        chk("pri_busy", 32'(bus.o_busy), 0);
        cyc("pri_start", 0, 0, 1, 0);
        cyc("pri_ss", 0, 0, 1, 1);
        chk("pri_ss_busy", 32'(bus.o_busy), 0);

        // zero cases
        cyc("z_load", 1, 0, 0, 0);
        tc_count = 0;
        cyc("z_start", 0, 0, 1, 0);
        idle("z_wait", 5);
        chk("z_no_tc", tc_count, 0);
        cyc("d_load", 1, 4, 0, 0);
        cyc("d_start", 0, 0, 1, 0);
        idle("d_run", 5);
        cyc("d_restart", 0, 0, 1, 0);
`ifndef TIMER_AUTORELOAD_EN
        chk("d_rearm_data", 32'(bus.o_data), 4);
        chk("d_rearm_busy", 32'(bus.o_busy), 1);
`endif

        // periodic window: 20 cycles from reload 4
`ifdef TIMER_AUTORELOAD_EN
        exp_pulses = 5;
`else
        exp_pulses = 1;
`endif
        cyc("ar_load", 1, 4, 0, 0);
        cyc("ar_start", 0, 0, 1, 0);
        tc_count = 0;
        idle("ar_run", 20);
        chk("ar_pulses", tc_count, exp_pulses);

        // reset mid-run at count 5: immediate clear, no later pulse
        cyc("mr_load", 1, 8, 0, 0);
        cyc("mr_start", 0, 0, 1, 0);
        idle("mr_run", 3);
        chk("mr_pre", 32'(bus.o_data), 5);
        #2 i_rst = 1'b0;
        #1;
        model_reset();
        chk("mr_data", 32'(bus.o_data), 0);
        chk("mr_busy", 32'(bus.o_busy), 0);
        chk("mr_tc",   32'(bus.o_tc),   0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
        tc_count = 0;
        idle("mr_after", 12);
        chk("mr_no_tc", tc_count, 0);

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            bit le, st, sp;
            int unsigned d;
            le = ($urandom_range(0, 24) == 0);
            sp = ($urandom_range(0, 19) == 0);
            st = ($urandom_range(0, 5) == 0);
            d  = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 9);
            cyc("rnd", le, d, st, sp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
